// File: rtl/ep_mem_ctrl_pkg.sv
// Shared types for the queued PCIe endpoint memory controller: completion request
// payload, FSM state encoding and header field widths.
package ep_mem_ctrl_pkg;

    localparam int unsigned TC_W      = 3;
    localparam int unsigned ATTR_W    = 2;
    localparam int unsigned LEN_W     = 10;
    localparam int unsigned RID_W     = 16;
    localparam int unsigned TAG_W     = 8;
    localparam int unsigned CBE_W     = 8;
    localparam int unsigned LADDR_W   = 13;
    localparam int unsigned CPL_CNT_W = 16;

    typedef struct packed {
        logic               with_data;
        logic [TC_W-1:0]    tc;
        logic               td;
        logic               ep;
        logic [ATTR_W-1:0]  attr;
        logic [LEN_W-1:0]   len;
        logic [RID_W-1:0]   rid;
        logic [TAG_W-1:0]   tag;
        logic [CBE_W-1:0]   be;
        logic [LADDR_W-1:0] addr;
    } cpl_req_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOAD         = 2'd1,
        WAIT_TX_CPLT = 2'd2
    } cpl_state_e;

endpackage

// File: rtl/ep_mem_ctrl_q_if.sv
// RX/TX facing bus of ep_mem_ctrl_q: request push, completion handshake and the
// register file read/write ports. slave = controller side, master = environment side.
interface ep_mem_ctrl_q_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 11
);
    import ep_mem_ctrl_pkg::*;

    localparam int unsigned BE_W = DATA_W / 8;

    logic                 rx_np_ok;
    logic                 req_push_i;
    logic                 req_with_data_i;
    logic [TC_W-1:0]      req_tc_i;
    logic                 req_td_i;
    logic                 req_ep_i;
    logic [ATTR_W-1:0]    req_attr_i;
    logic [LEN_W-1:0]     req_len_i;
    logic [RID_W-1:0]     req_rid_i;
    logic [TAG_W-1:0]     req_tag_i;
    logic [CBE_W-1:0]     req_be_i;
    logic [LADDR_W-1:0]   req_addr_i;
    logic                 req_ovf_o;

    logic                 cpl_valid_o;
    logic                 cpl_with_data_o;
    logic [TC_W-1:0]      cpl_tc_o;
    logic                 cpl_td_o;
    logic                 cpl_ep_o;
    logic [ATTR_W-1:0]    cpl_attr_o;
    logic [LEN_W-1:0]     cpl_len_o;
    logic [RID_W-1:0]     cpl_rid_o;
    logic [TAG_W-1:0]     cpl_tag_o;
    logic [CBE_W-1:0]     cpl_be_o;
    logic [LADDR_W-1:0]   cpl_addr_o;
    logic                 txe_compl_done_i;
    logic [CPL_CNT_W-1:0] cpl_cnt_o;

    logic [ADDR_W-1:0]    rd_addr_i;
    logic [BE_W-1:0]      rd_be_i;
    logic [DATA_W-1:0]    rd_data_o;
    logic                 wr_en_i;
    logic [ADDR_W-1:0]    wr_addr_i;
    logic [BE_W-1:0]      wr_be_i;
    logic [DATA_W-1:0]    wr_data_i;
    logic                 wr_busy_o;

    modport slave (
        output rx_np_ok, req_ovf_o,
        input  req_push_i, req_with_data_i, req_tc_i, req_td_i, req_ep_i, req_attr_i,
        input  req_len_i, req_rid_i, req_tag_i, req_be_i, req_addr_i,
        output cpl_valid_o, cpl_with_data_o, cpl_tc_o, cpl_td_o, cpl_ep_o, cpl_attr_o,
        output cpl_len_o, cpl_rid_o, cpl_tag_o, cpl_be_o, cpl_addr_o, cpl_cnt_o,
        input  txe_compl_done_i,
        input  rd_addr_i, rd_be_i, wr_en_i, wr_addr_i, wr_be_i, wr_data_i,
        output rd_data_o, wr_busy_o
    );

    modport master (
        input  rx_np_ok, req_ovf_o,
        output req_push_i, req_with_data_i, req_tc_i, req_td_i, req_ep_i, req_attr_i,
        output req_len_i, req_rid_i, req_tag_i, req_be_i, req_addr_i,
        input  cpl_valid_o, cpl_with_data_o, cpl_tc_o, cpl_td_o, cpl_ep_o, cpl_attr_o,
        input  cpl_len_o, cpl_rid_o, cpl_tag_o, cpl_be_o, cpl_addr_o, cpl_cnt_o,
        output txe_compl_done_i,
        output rd_addr_i, rd_be_i, wr_en_i, wr_addr_i, wr_be_i, wr_data_i,
        input  rd_data_o, wr_busy_o
    );

endinterface

// File: rtl/ep_cpl_fifo.sv
// Circular FIFO of completion requests with one extra pointer bit for full/empty.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module ep_cpl_fifo
    import ep_mem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  cpl_req_t                     din,
    input  logic                         pop,
    output cpl_req_t                     dout_c,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full_c,
    output logic                         empty_c
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    cpl_req_t        mem [DEPTH];
    logic [CW-1:0]   wptr;
    logic [CW-1:0]   rptr;
    logic            push_ok;
    logic            pop_ok;

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);
    assign push_ok = push && (!full_c || pop);
    assign pop_ok  = pop && !empty_c;
    assign dout_c  = mem[rptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + CW'(1);
            if (pop_ok)  rptr <= rptr + CW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/ep_mem_ctrl_q.sv
// PCIe endpoint memory controller: queues non-posted completion requests for TX and
// owns a byte-enabled DWORD register file written by RX and read by TX.
module ep_mem_ctrl_q
    import ep_mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned REG_NUM = 16,
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned NP_HEAD = 1
) (
    input  logic           clk,
    input  logic           rst,
    ep_mem_ctrl_q_if.slave bus
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned CW     = $clog2(QDEPTH) + 1;
    localparam int unsigned RIDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    cpl_req_t             req_in;
    cpl_req_t             head;
    cpl_req_t             cpl_q;
    cpl_req_t             cpl_d;
    logic [CW-1:0]        count;
    logic                 full_c;
    logic                 empty_c;
    logic                 pop;
    cpl_state_e           state_q;
    cpl_state_e           state_d;
    logic                 valid_q;
    logic                 valid_d;
    logic [CPL_CNT_W-1:0] cnt_q;
    logic [CPL_CNT_W-1:0] cnt_d;
    logic                 ovf_q;

    assign req_in = '{
        with_data: bus.req_with_data_i, tc: bus.req_tc_i, td: bus.req_td_i,
        ep: bus.req_ep_i, attr: bus.req_attr_i, len: bus.req_len_i,
        rid: bus.req_rid_i, tag: bus.req_tag_i, be: bus.req_be_i, addr: bus.req_addr_i
    };

    // The presented entry stays queued until TX retires it, so count covers it too.
    ep_cpl_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.req_push_i),
        .din     (req_in),
        .pop     (pop),
        .dout_c  (head),
        .count   (count),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    assign bus.rx_np_ok = (QDEPTH - 32'(count)) > NP_HEAD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            cpl_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            cpl_q   <= cpl_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_q | (bus.req_push_i && full_c && !pop);
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        cpl_d   = cpl_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_c) state_d = LOAD;
            end
            LOAD: begin
                cpl_d   = head;
                valid_d = 1'b1;
                state_d = WAIT_TX_CPLT;
            end
            WAIT_TX_CPLT: begin
                if (bus.txe_compl_done_i) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + CPL_CNT_W'(1);
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ovf_o       = ovf_q;
    assign bus.cpl_valid_o     = valid_q;
    assign bus.cpl_cnt_o       = cnt_q;
    assign bus.cpl_with_data_o = cpl_q.with_data;
    assign bus.cpl_tc_o        = cpl_q.tc;
    assign bus.cpl_td_o        = cpl_q.td;
    assign bus.cpl_ep_o        = cpl_q.ep;
    assign bus.cpl_attr_o      = cpl_q.attr;
    assign bus.cpl_len_o       = cpl_q.len;
    assign bus.cpl_rid_o       = cpl_q.rid;
    assign bus.cpl_tag_o       = cpl_q.tag;
    assign bus.cpl_be_o        = cpl_q.be;
    assign bus.cpl_addr_o      = cpl_q.addr;

    logic [DATA_W-1:0] regs [REG_NUM];
    logic              wr_busy_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [BE_W-1:0]   wr_be_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_mask;
    logic [DATA_W-1:0] rd_q;
    logic              wr_hit;
    logic              rd_hit;

    assign wr_hit = wr_addr_q < ADDR_W'(REG_NUM);
    assign rd_hit = bus.rd_addr_i < ADDR_W'(REG_NUM);

    // Merge of captured enabled bytes over the current register value.
    always_comb begin
        merged = regs[wr_addr_q[RIDX_W-1:0]];
        for (int b = 0; b < int'(BE_W); b++) begin
            if (wr_be_q[b]) merged[b*8 +: 8] = wr_data_q[b*8 +: 8];
        end
    end

    always_comb begin
        rd_mask = '0;
        for (int b = 0; b < int'(BE_W); b++) begin
            rd_mask[b*8 +: 8] = {8{bus.rd_be_i[b]}};
        end
    end

    // Capture edge then merge edge; wr_en_i during the merge cycle is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_busy_q <= 1'b0;
            wr_addr_q <= '0;
            wr_be_q   <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < int'(REG_NUM); i++) regs[i] <= '0;
        end else if (wr_busy_q) begin
            wr_busy_q <= 1'b0;
            if (wr_hit) regs[wr_addr_q[RIDX_W-1:0]] <= merged;
        end else if (bus.wr_en_i) begin
            wr_busy_q <= 1'b1;
            wr_addr_q <= bus.wr_addr_i;
            wr_be_q   <= bus.wr_be_i;
            wr_data_q <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_q <= '0;
        else     rd_q <= rd_hit ? (regs[bus.rd_addr_i[RIDX_W-1:0]] & rd_mask) : '0;
    end

    assign bus.rd_data_o = rd_q;
    assign bus.wr_busy_o = wr_busy_q;

endmodule
